// File: rtl/ecg_pkg.sv
// Shared encodings and shift constants for the R-peak control path.
package ecg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALIB  = 2'd1,
    ST_RUN    = 2'd2,
    ST_SEARCH = 2'd3
  } state_e;

  // 5/8 * x is formed as (x >>> FRAC_SH_A) + (x >>> FRAC_SH_B)
  localparam int unsigned FRAC_SH_A = 1;
  localparam int unsigned FRAC_SH_B = 3;
  // Level tracker weight: level moves 1/8 of the way toward each beat amplitude
  localparam int unsigned LVL_SH    = 3;

endpackage

// File: rtl/sample_tick_gen.sv
// Clock divider producing a one-clk sample strobe every DIV clks while enabled.
module sample_tick_gen #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/r_peak_scheduler.sv
// Controller for r_peak_detector: sample strobe, adaptive threshold,
// RR interval measurement and missed-beat watchdog.
module r_peak_scheduler
  import ecg_pkg::*;
#(
  parameter int unsigned        SAMPLE_DIV  = 1000,
  parameter int unsigned        CAL_SAMPLES = 720,
  parameter int unsigned        TIMEOUT     = 720,
  parameter logic signed [15:0] INIT_THR    = 16'sd7300,
  parameter logic signed [15:0] MIN_THR     = 16'sd1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic signed [15:0] ecg_in,
  input  logic               r_peak,
  output logic               sample_en,
  output logic signed [15:0] threshold,
  output logic [15:0]        rr_interval,
  output logic               rr_valid,
  output logic               beat_lost,
  output logic               calib_done,
  output logic [1:0]         state
);

  localparam int unsigned CCW = $clog2(CAL_SAMPLES + 1);
  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CCW-1:0] CAL_LAST = CCW'(CAL_SAMPLES - 1);
  localparam logic [WCW-1:0] WD_LAST  = WCW'(TIMEOUT - 1);

  function automatic logic signed [16:0] sext17(input logic signed [15:0] x);
    return $signed({x[15], x});
  endfunction

  function automatic logic signed [16:0] five_eighths(input logic signed [15:0] x);
    logic signed [16:0] xe;
    xe = sext17(x);
    return (xe >>> FRAC_SH_A) + (xe >>> FRAC_SH_B);
  endfunction

  function automatic logic signed [15:0] clamp_thr(input logic signed [16:0] x);
    logic signed [16:0] lo;
    lo = sext17(MIN_THR);
    if (x > 17'sd32767)  return 16'sd32767;
    else if (x < lo)     return MIN_THR;
    else                 return x[15:0];
  endfunction

  logic                      w_tick;
  state_e                    r_state, w_state_nxt;
  logic signed [15:0]        r_thr, w_thr_nxt;
  logic signed [15:0]        r_level, w_level_nxt;
  logic signed [15:0]        r_amp, w_amp_nxt;
  logic [15:0]               r_sp, w_sp_nxt;
  logic [15:0]               r_rr, w_rr_nxt;
  logic [CCW-1:0]            r_cal_cnt, w_cal_nxt;
  logic [WCW-1:0]            r_wd_cnt, w_wd_nxt;
  logic                      r_rr_vld, w_rr_vld_nxt;
  logic                      r_lost, w_lost_nxt;
  logic                      r_cd, w_cd_nxt;
  logic                      r_first, w_first_nxt;
  logic [15:0]               w_sp_inc;
  logic signed [15:0]        w_amp_cur, w_lvl_cal, w_lvl_adapt;
  logic signed [16:0]        w_lvl_sum;

  sample_tick_gen #(
    .DIV(SAMPLE_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (enable),
    .i_clr (!enable),
    .o_tick(w_tick)
  );

  // Candidate values for the current sample; amp and level include ecg_in itself
  assign w_sp_inc    = (r_sp == 16'hFFFF) ? r_sp : r_sp + 16'd1;
  assign w_amp_cur   = (ecg_in > r_amp)   ? ecg_in : r_amp;
  assign w_lvl_cal   = (ecg_in > r_level) ? ecg_in : r_level;
  assign w_lvl_sum   = sext17(r_level) - (sext17(r_level) >>> LVL_SH)
                     + (sext17(w_amp_cur) >>> LVL_SH);
  assign w_lvl_adapt = w_lvl_sum[15:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_thr_nxt    = r_thr;
    w_level_nxt  = r_level;
    w_amp_nxt    = r_amp;
    w_sp_nxt     = r_sp;
    w_rr_nxt     = r_rr;
    w_cal_nxt    = r_cal_cnt;
    w_wd_nxt     = r_wd_cnt;
    w_rr_vld_nxt = 1'b0;
    w_lost_nxt   = 1'b0;
    w_cd_nxt     = r_cd;
    w_first_nxt  = r_first;

    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_thr_nxt   = INIT_THR;
      w_level_nxt = '0;
      w_amp_nxt   = '0;
      w_sp_nxt    = '0;
      w_cal_nxt   = '0;
      w_wd_nxt    = '0;
      w_cd_nxt    = 1'b0;
      w_first_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: w_state_nxt = ST_CALIB;

        ST_CALIB: begin
          if (w_tick) begin
            w_level_nxt = w_lvl_cal;
            w_cal_nxt   = r_cal_cnt + CCW'(1);
            if (r_cal_cnt == CAL_LAST) begin
              w_thr_nxt   = clamp_thr(five_eighths(w_lvl_cal));
              w_cd_nxt    = 1'b1;
              w_sp_nxt    = '0;
              w_wd_nxt    = '0;
              w_first_nxt = 1'b1;
              w_state_nxt = ST_RUN;
            end
          end
        end

        default: begin
          if (w_tick) begin
            w_sp_nxt  = w_sp_inc;
            w_amp_nxt = w_amp_cur;
            w_wd_nxt  = r_wd_cnt + WCW'(1);
            // A peak on the expiry sample takes priority over the watchdog
            if (r_peak) begin
              w_rr_nxt     = w_sp_inc;
              w_rr_vld_nxt = !r_first;
              w_first_nxt  = 1'b0;
              w_sp_nxt     = '0;
              w_wd_nxt     = '0;
              w_amp_nxt    = '0;
              w_level_nxt  = w_lvl_adapt;
              w_thr_nxt    = clamp_thr(five_eighths(w_lvl_adapt));
              w_state_nxt  = ST_RUN;
            end else if (r_wd_cnt == WD_LAST) begin
              w_wd_nxt    = '0;
              w_lost_nxt  = 1'b1;
              w_thr_nxt   = clamp_thr(sext17(r_thr) >>> 1);
              w_first_nxt = 1'b1;
              w_state_nxt = ST_SEARCH;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_thr     <= INIT_THR;
      r_level   <= '0;
      r_amp     <= '0;
      r_sp      <= '0;
      r_rr      <= '0;
      r_cal_cnt <= '0;
      r_wd_cnt  <= '0;
      r_rr_vld  <= 1'b0;
      r_lost    <= 1'b0;
      r_cd      <= 1'b0;
      r_first   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_thr     <= w_thr_nxt;
      r_level   <= w_level_nxt;
      r_amp     <= w_amp_nxt;
      r_sp      <= w_sp_nxt;
      r_rr      <= w_rr_nxt;
      r_cal_cnt <= w_cal_nxt;
      r_wd_cnt  <= w_wd_nxt;
      r_rr_vld  <= w_rr_vld_nxt;
      r_lost    <= w_lost_nxt;
      r_cd      <= w_cd_nxt;
      r_first   <= w_first_nxt;
    end
  end

  assign sample_en   = w_tick;
  assign threshold   = r_thr;
  assign rr_interval = r_rr;
  assign rr_valid    = r_rr_vld;
  assign beat_lost   = r_lost;
  assign calib_done  = r_cd;
  assign state       = r_state;

endmodule
